axi_write_arbiter: RTL
======================

# axi_write_arbiter

Two-master arbiter that shares one AXI3 write slave port (AW, W and B channels) between two write masters. It sits between the write-master instances and the write-slave/interconnect port. It grants one master per transaction with round-robin priority and holds that grant across the address, data and response phases. It also counts W beats against AWLEN and flags a burst-length mismatch.

## Interface
- Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- Ports (n = 0, 1 for each master-side port):
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  synchronous active-low reset
- Mn_AWVALID  in  1  master n address valid
- Mn_AWID  in  4  master n write ID
- Mn_AWADDR  in  ADDR_W  master n address
- Mn_AWLEN  in  4  master n burst length minus 1
- Mn_AWSIZE  in  3  master n beat size
- Mn_AWBURST  in  2  master n burst type
- Mn_AWREADY  out  1  address ready to master n
- Mn_WVALID  in  1  master n data valid
- Mn_WDATA  in  DATA_W  master n write data
- Mn_WSTRB  in  4  master n byte strobes
- Mn_WLAST  in  1  master n last beat
- Mn_WREADY  out  1  data ready to master n
- Mn_BVALID  out  1  response valid to master n
- Mn_BRESP  out  2  response code to master n
- Mn_BID  out  4  response ID to master n
- Mn_BREADY  in  1  master n response ready
- S_AWVALID / S_AWID / S_AWADDR / S_AWLEN / S_AWSIZE / S_AWBURST  out  1/4/ADDR_W/4/3/2  address channel to slave
- S_AWREADY  in  1  slave address ready
- S_WVALID / S_WDATA / S_WSTRB / S_WLAST  out  1/DATA_W/4/1  data channel to slave
- S_WREADY  in  1  slave data ready
- S_BVALID / S_BRESP / S_BID  in  1/2/4  response from slave
- S_BREADY  out  1  response ready to slave
- grant  out  2  one-hot owner of the port, 00 when idle
- len_err  out  1  sticky burst-length mismatch flag

## Operation
- FSM has four states: IDLE, ADDR, DATA, RESP. Reset enters IDLE with grant=00, prio=M0, beat counter 0 and len_err=0.
- IDLE:
  - If any Mn_AWVALID is high, register the winner, set grant and go to ADDR.
  - If both request, the winner is the master selected by prio.
  - The AW payload is not consumed in IDLE.
- ADDR:
  - The granted master's AW fields and AWVALID pass combinationally to S_AW*. The granted Mn_AWREADY equals S_AWREADY.
  - The non-granted Mn_AWREADY is 0.
  - On the S_AWVALID && S_AWREADY handshake, latch AWLEN into len_q, clear the beat counter and go to DATA.
- DATA:
  - The granted master's W signals pass to S_W*. The granted Mn_WREADY equals S_WREADY.
  - Each W handshake increments the beat counter.
  - On a handshake with WLAST=1, go to RESP.
  - If WLAST arrives when count is not equal to len_q, or count reaches len_q without WLAST, set len_err. len_err stays high until reset.
  - The transaction still proceeds to RESP when WLAST is seen.
- RESP:
  - S_BVALID, S_BRESP and S_BID route to the granted master only. S_BREADY equals the granted Mn_BREADY.
  - On the B handshake, flip prio to the other master, clear grant and return to IDLE.
- Non-granted masters always see AWREADY=WREADY=BVALID=0.
- Outside the matching state, every S_* valid and every Mn_* ready is 0. S_BREADY is 0 outside RESP.
- W data presented before its own AW handshake is not forwarded. Write interleaving is not supported.

## Timing
- Arbitration latency: 1 cycle from AWVALID in IDLE to S_AWVALID.
- Fastest single-beat transaction: 4 cycles total (IDLE, ADDR, DATA, RESP), with one cycle per state when the slave is always ready.
- Back-to-back transactions: one IDLE bubble between the B handshake and the next grant.
- Forwarding in ADDR, DATA and RESP is combinational, with no added latency.
- Mn_AWREADY, Mn_WREADY and S_BREADY must not depend combinationally on the same-side valid beyond the pass-through mux.
- The beat counter is 4 bits, and a 16-beat burst (AWLEN=15) counts 0..15 without wrap.
- A requester deasserting AWVALID after the grant is a master protocol violation. The arbiter stays in ADDR until the handshake occurs.
- ARESETn low in any state returns to IDLE on the next edge and drives every output to 0, including mid-burst and during RESP.

## Test plan
- Single master M0, AWLEN=0, slave always ready -> S_AWVALID in cycle 2, one W beat with WLAST, M0_BVALID/BRESP=00 in cycle 4, grant returns to 00.
- M0 and M1 request simultaneously, twice -> first grant=01 (M0), second grant=10 (M1), one IDLE cycle between them.
- M1 4-beat burst (AWLEN=3) with S_WREADY toggling every other cycle -> 4 data beats forwarded in order, WLAST on the 4th beat, len_err=0.
- M0 sends AWLEN=3 but asserts WLAST on beat 2 -> len_err=1 and remains 1, transaction completes, BVALID still routed to M0.
- Slave delays S_BVALID by 5 cycles while M1 requests -> M1_AWREADY stays 0 until M0's B handshake, then M1 is granted.
- Assert ARESETn=0 mid-DATA -> next cycle grant=00, all valids/readies 0, len_err=0, FSM in IDLE.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
//
// Shares one AXI3 write slave port (AW, W, B) between two write masters.
// One master owns the port for a whole transaction: the grant is taken in
// IDLE, then held through the address, data and response phases.
// Ownership alternates round-robin when both masters request together.
// W beats are counted against the accepted AWLEN. Any disagreement between
// the count and WLAST raises a sticky len_err flag.
//
// Ports
//   ACLK, ARESETn          clock (rising edge), synchronous active-low reset
//   M0_* / M1_*            master-side AW/W inputs, AWREADY/WREADY/B* outputs
//   S_*                    slave-side AW/W outputs, AWREADY/WREADY/B* inputs
//   grant                  one-hot owner of the slave port, 00 when idle
//   len_err                sticky burst-length mismatch flag
// ---------------------------------------------------------------------------
module axi_write_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0
  input  logic              M0_AWVALID,
  input  logic [3:0]        M0_AWID,
  input  logic [ADDR_W-1:0] M0_AWADDR,
  input  logic [3:0]        M0_AWLEN,
  input  logic [2:0]        M0_AWSIZE,
  input  logic [1:0]        M0_AWBURST,
  output logic              M0_AWREADY,
  input  logic              M0_WVALID,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic [3:0]        M0_WSTRB,
  input  logic              M0_WLAST,
  output logic              M0_WREADY,
  output logic              M0_BVALID,
  output logic [1:0]        M0_BRESP,
  output logic [3:0]        M0_BID,
  input  logic              M0_BREADY,
  // master 1
  input  logic              M1_AWVALID,
  input  logic [3:0]        M1_AWID,
  input  logic [ADDR_W-1:0] M1_AWADDR,
  input  logic [3:0]        M1_AWLEN,
  input  logic [2:0]        M1_AWSIZE,
  input  logic [1:0]        M1_AWBURST,
  output logic              M1_AWREADY,
  input  logic              M1_WVALID,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic [3:0]        M1_WSTRB,
  input  logic              M1_WLAST,
  output logic              M1_WREADY,
  output logic              M1_BVALID,
  output logic [1:0]        M1_BRESP,
  output logic [3:0]        M1_BID,
  input  logic              M1_BREADY,
  // slave port
  output logic              S_AWVALID,
  output logic [3:0]        S_AWID,
  output logic [ADDR_W-1:0] S_AWADDR,
  output logic [3:0]        S_AWLEN,
  output logic [2:0]        S_AWSIZE,
  output logic [1:0]        S_AWBURST,
  input  logic              S_AWREADY,
  output logic              S_WVALID,
  output logic [DATA_W-1:0] S_WDATA,
  output logic [3:0]        S_WSTRB,
  output logic              S_WLAST,
  input  logic              S_WREADY,
  input  logic              S_BVALID,
  input  logic [1:0]        S_BRESP,
  input  logic [3:0]        S_BID,
  output logic              S_BREADY,
  // status
  output logic [1:0]        grant,
  output logic              len_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_grant;
  logic        r_prio;      // 0: M0 wins a tie, 1: M1 wins a tie
  logic [3:0]  r_cnt;       // index of the current W beat
  logic [3:0]  r_len;       // AWLEN accepted by the slave
  logic        r_len_err;

  logic        w_sel;       // 1 when M1 owns the port
  logic        w_any_req;
  logic        w_win_m1;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;

  assign w_sel     = r_grant[1];
  assign w_any_req = M0_AWVALID | M1_AWVALID;
  // With both requesting the priority pointer decides, otherwise the lone requester wins.
  assign w_win_m1  = (M0_AWVALID && M1_AWVALID) ? r_prio : M1_AWVALID;

  // Valids/readies below are already gated by state, so these are phase-qualified.
  assign w_aw_hs = S_AWVALID && S_AWREADY;
  assign w_w_hs  = S_WVALID && S_WREADY;
  assign w_b_hs  = S_BVALID && S_BREADY;

  assign grant   = r_grant;
  assign len_err = r_len_err;

  // ---------------- state register ----------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req)         w_state_next = ST_ADDR;
      ST_ADDR: if (w_aw_hs)           w_state_next = ST_DATA;
      ST_DATA: if (w_w_hs && S_WLAST) w_state_next = ST_RESP;
      ST_RESP: if (w_b_hs)            w_state_next = ST_IDLE;
      default:                        w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- grant, priority, beat tracking ----------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_grant   <= 2'b00;
      r_prio    <= 1'b0;
      r_cnt     <= 4'd0;
      r_len     <= 4'd0;
      r_len_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_win_m1 ? 2'b10 : 2'b01;
          end
        end
        ST_ADDR: begin
          if (w_aw_hs) begin
            r_len <= S_AWLEN;
            r_cnt <= 4'd0;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            // WLAST must coincide exactly with the beat whose index equals AWLEN.
            if (S_WLAST != (r_cnt == r_len)) begin
              r_len_err <= 1'b1;
            end
            // Saturate so an overlong burst cannot wrap back onto a valid index.
            if (r_cnt != 4'hF) begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_prio  <= ~w_sel;  // the master just served yields the next tie
            r_grant <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- channel routing ----------------
  always_comb begin
    S_AWVALID  = 1'b0;
    S_AWID     = '0;
    S_AWADDR   = '0;
    S_AWLEN    = '0;
    S_AWSIZE   = '0;
    S_AWBURST  = '0;
    S_WVALID   = 1'b0;
    S_WDATA    = '0;
    S_WSTRB    = '0;
    S_WLAST    = 1'b0;
    S_BREADY   = 1'b0;
    M0_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M0_BVALID  = 1'b0;
    M0_BRESP   = '0;
    M0_BID     = '0;
    M1_AWREADY = 1'b0;
    M1_WREADY  = 1'b0;
    M1_BVALID  = 1'b0;
    M1_BRESP   = '0;
    M1_BID     = '0;
    case (r_state)
      ST_ADDR: begin
        if (w_sel) begin
          S_AWVALID  = M1_AWVALID;
          S_AWID     = M1_AWID;
          S_AWADDR   = M1_AWADDR;
          S_AWLEN    = M1_AWLEN;
          S_AWSIZE   = M1_AWSIZE;
          S_AWBURST  = M1_AWBURST;
          M1_AWREADY = S_AWREADY;
        end else begin
          S_AWVALID  = M0_AWVALID;
          S_AWID     = M0_AWID;
          S_AWADDR   = M0_AWADDR;
          S_AWLEN    = M0_AWLEN;
          S_AWSIZE   = M0_AWSIZE;
          S_AWBURST  = M0_AWBURST;
          M0_AWREADY = S_AWREADY;
        end
      end
      ST_DATA: begin
        if (w_sel) begin
          S_WVALID  = M1_WVALID;
          S_WDATA   = M1_WDATA;
          S_WSTRB   = M1_WSTRB;
          S_WLAST   = M1_WLAST;
          M1_WREADY = S_WREADY;
        end else begin
          S_WVALID  = M0_WVALID;
          S_WDATA   = M0_WDATA;
          S_WSTRB   = M0_WSTRB;
          S_WLAST   = M0_WLAST;
          M0_WREADY = S_WREADY;
        end
      end
      ST_RESP: begin
        if (w_sel) begin
          S_BREADY  = M1_BREADY;
          M1_BVALID = S_BVALID;
          M1_BRESP  = S_BRESP;
          M1_BID    = S_BID;
        end else begin
          S_BREADY  = M0_BREADY;
          M0_BVALID = S_BVALID;
          M0_BRESP  = S_BRESP;
          M0_BID    = S_BID;
        end
      end
      default: ;
    endcase
  end

endmodule
